// File: rtl/fetch_unit.sv
// Instruction fetch stage: one word per cycle from synchronous IMEM, with stall hold slot and epoch-tagged branch redirect.
// Optional macro FETCH_PC_OUT_EN adds the ARM-visible pc_out path (fetch address + 8); otherwise pc_out is tied to zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sel_stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_addr,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr_out,
    output logic               branch_out,
    output logic               branch_ref,
    output logic [31:0]        pc_out
);

    localparam logic [31:0] NOP = 32'hE320_F000;

    logic [31:0] pc_q, pc_d;
    logic        epoch_q, epoch_d;
    logic        inflight_v_q, inflight_v_d;
    logic        inflight_tag_q, inflight_tag_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        hold_tag_q, hold_tag_d;
`ifdef FETCH_PC_OUT_EN
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
`endif

    assign imem_en    = !rst && !sel_stall && !branch_taken;
    assign imem_addr  = pc_q[IMEM_AW+1:2];
    assign branch_ref = epoch_q;

    // Presented instruction: the held word wins over the word just returned from memory.
    always_comb begin
        instr_out  = NOP;
        branch_out = epoch_q;
        pc_out     = 32'h0;
        if (hold_v_q) begin
            instr_out  = hold_instr_q;
            branch_out = hold_tag_q;
`ifdef FETCH_PC_OUT_EN
            pc_out     = hold_pc_q;
`endif
        end else if (inflight_v_q) begin
            instr_out  = imem_rdata;
            branch_out = inflight_tag_q;
`ifdef FETCH_PC_OUT_EN
            pc_out     = inflight_pc_q + 32'd8;
`endif
        end
    end

    always_comb begin
        pc_d           = pc_q;
        epoch_d        = epoch_q;
        inflight_v_d   = imem_en;
        inflight_tag_d = inflight_tag_q;
        hold_v_d       = hold_v_q;
        hold_instr_d   = hold_instr_q;
        hold_tag_d     = hold_tag_q;
`ifdef FETCH_PC_OUT_EN
        inflight_pc_d  = inflight_pc_q;
        hold_pc_d      = hold_pc_q;
`endif
        if (imem_en) begin
            pc_d           = pc_q + 32'd4;
            inflight_tag_d = epoch_q;
`ifdef FETCH_PC_OUT_EN
            inflight_pc_d  = pc_q;
`endif
        end
        // A redirect squashes everything younger, including a word parked by a concurrent stall.
        if (branch_taken) begin
            pc_d     = branch_addr;
            epoch_d  = ~epoch_q;
            hold_v_d = 1'b0;
        end else if (sel_stall) begin
            if (!hold_v_q) begin
                hold_v_d     = 1'b1;
                hold_instr_d = instr_out;
                hold_tag_d   = branch_out;
`ifdef FETCH_PC_OUT_EN
                hold_pc_d    = pc_out;
`endif
            end
        end else begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            epoch_q        <= 1'b0;
            inflight_v_q   <= 1'b0;
            inflight_tag_q <= 1'b0;
            hold_v_q       <= 1'b0;
            hold_instr_q   <= NOP;
            hold_tag_q     <= 1'b0;
`ifdef FETCH_PC_OUT_EN
            inflight_pc_q  <= 32'h0;
            hold_pc_q      <= 32'h0;
`endif
        end else begin
            pc_q           <= pc_d;
            epoch_q        <= epoch_d;
            inflight_v_q   <= inflight_v_d;
            inflight_tag_q <= inflight_tag_d;
            hold_v_q       <= hold_v_d;
            hold_instr_q   <= hold_instr_d;
            hold_tag_q     <= hold_tag_d;
`ifdef FETCH_PC_OUT_EN
            inflight_pc_q  <= inflight_pc_d;
            hold_pc_q      <= hold_pc_d;
`endif
        end
    end

endmodule
